processing_swap_control: RTL and testbench

Sequences two instances of the swappable processing unit (A, B) in ping-pong fashion across a reconstruction pass of `pNoOfItrs` iterations. It fetches per-iteration accumulator parameters from a registered parameter LUT and hands each iteration to a unit for filling. It then grants each filled unit the PE datapath in iteration order, so that one unit fills while the other shifts into the PEs. It sits between the top-level pass control and the two swappable units, and drives the PE tap/enable mux select.

---
 rtl/processing_swap_control_pkg.sv | 23 ++
 rtl/processing_swap_control_tracker.sv | 48 ++++
 rtl/processing_swap_control.sv | 174 +++++++++++++++++
 tb/tb_processing_swap_control.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/processing_swap_control_pkg.sv
// Shared widths, defaults and FSM state type for the swap control and the
// swappable processing units.
package processing_swap_control_pkg;

    localparam int unsigned kNoOfItrs          = 90;
    localparam int unsigned kItrLength         = 7;
    localparam int unsigned kShAccuBaseLength  = 16;
    localparam int unsigned kMapAccuInitLength = 16;
    localparam int unsigned kMapAccuBaseLength = 16;

    typedef logic [kShAccuBaseLength-1:0]  tShiftAccuBase;
    typedef logic [kMapAccuInitLength-1:0] tMapAccuInit;
    typedef logic [kMapAccuBaseLength-1:0] tMapAccuBase;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StIssue,
        StDrain
    } swc_state_e;

endpackage

// File: rtl/processing_swap_control_tracker.sv
// Per-unit shifting flag and registered ack pulses for one swappable unit.
module swap_unit_tracker (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_next_itr_i,
    input  logic issue_grant_i,
    input  logic swap_grant_i,
    output logic shifting_o,
    output logic next_itr_ack_o,
    output logic swap_ack_o
);

    logic shifting_q, shifting_d;
    logic next_itr_ack_q, next_itr_ack_d;
    logic swap_ack_q, swap_ack_d;

    always_comb begin
        shifting_d     = shifting_q;
        next_itr_ack_d = issue_grant_i;
        swap_ack_d     = swap_grant_i;
        if (sw_next_itr_i) begin
            shifting_d = 1'b0;
        end
        if (swap_grant_i) begin
            shifting_d = 1'b1;
        end
    end

    // Flag with this cycle's clear already applied, so a unit finishing its shift
    // can be served (or unblock its peer) in the very cycle it requests.
    assign shifting_o = shifting_q & ~sw_next_itr_i;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shifting_q     <= 1'b0;
            next_itr_ack_q <= 1'b0;
            swap_ack_q     <= 1'b0;
        end else begin
            shifting_q     <= shifting_d;
            next_itr_ack_q <= next_itr_ack_d;
            swap_ack_q     <= swap_ack_d;
        end
    end

    assign next_itr_ack_o = next_itr_ack_q;
    assign swap_ack_o     = swap_ack_q;

endmodule

// File: rtl/processing_swap_control.sv
// Ping-pong sequencer for two swappable units: issues per-iteration LUT parameters
// and grants the PE datapath to filled units in iteration order.
module processing_swap_control
    import processing_swap_control_pkg::*;
#(
    parameter int unsigned pNoOfItrs          = kNoOfItrs,
    parameter int unsigned pItrLength         = kItrLength,
    parameter int unsigned pShAccuBaseLength  = kShAccuBaseLength,
    parameter int unsigned pMapAccuInitLength = kMapAccuInitLength,
    parameter int unsigned pMapAccuBaseLength = kMapAccuBaseLength
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [pItrLength-1:0]         lut_addr,
    input  logic [pShAccuBaseLength-1:0]  lut_sh_accu_base,
    input  logic [pMapAccuInitLength-1:0] lut_mp_accu_init,
    input  logic [pMapAccuBaseLength-1:0] lut_mp_accu_base,
    output logic [pShAccuBaseLength-1:0]  sw_sh_accu_base,
    output logic [pMapAccuInitLength-1:0] sw_mp_accu_init,
    output logic [pMapAccuBaseLength-1:0] sw_mp_accu_base,
    input  logic                          sw_next_itr_a,
    input  logic                          sw_next_itr_b,
    input  logic                          sw_swap_a,
    input  logic                          sw_swap_b,
    output logic                          sw_next_itr_ack_a,
    output logic                          sw_next_itr_ack_b,
    output logic                          sw_swap_ack_a,
    output logic                          sw_swap_ack_b,
    output logic                          sel
);

    localparam logic [pItrLength:0] kItrs = (pItrLength + 1)'(pNoOfItrs);

    swc_state_e                    state_q, state_d;
    logic [pItrLength-1:0]         fi_q, fi_d, si_q, si_d, lut_addr_q, lut_addr_d;
    logic [pItrLength:0]           fi_inc;
    logic                          busy_q, busy_d, done_q, done_d, sel_q, sel_d;
    logic [pShAccuBaseLength-1:0]  sh_q, sh_d;
    logic [pMapAccuInitLength-1:0] mi_q, mi_d;
    logic [pMapAccuBaseLength-1:0] mb_q, mb_d;
    logic                          shift_a, shift_b;
    logic                          issue_a, issue_b, swap_g_a, swap_g_b;

    always_comb begin
        state_d    = state_q;
        fi_d       = fi_q;
        si_d       = si_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        lut_addr_d = lut_addr_q;
        sh_d       = sh_q;
        mi_d       = mi_q;
        mb_d       = mb_q;
        sel_d      = sel_q;
        issue_a    = 1'b0;
        issue_b    = 1'b0;
        swap_g_a   = 1'b0;
        swap_g_b   = 1'b0;
        fi_inc     = {1'b0, fi_q} + 1'b1;

        if (busy_q && (si_q < fi_q)) begin
            if (!si_q[0] && sw_swap_a && !shift_b) begin
                swap_g_a = 1'b1;
                sel_d    = 1'b0;
                si_d     = si_q + 1'b1;
            end else if (si_q[0] && sw_swap_b && !shift_a) begin
                swap_g_b = 1'b1;
                sel_d    = 1'b1;
                si_d     = si_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    fi_d       = '0;
                    si_d       = '0;
                    busy_d     = 1'b1;
                    lut_addr_d = '0;
                    state_d    = StFetch;
                end
            end
            StFetch: state_d = StLatch;
            StLatch: begin
                sh_d    = lut_sh_accu_base;
                mi_d    = lut_mp_accu_init;
                mb_d    = lut_mp_accu_base;
                state_d = StIssue;
            end
            StIssue: begin
                issue_a = !fi_q[0] && sw_next_itr_a && !shift_a;
                issue_b = fi_q[0] && sw_next_itr_b && !shift_b;
                if (issue_a || issue_b) begin
                    fi_d = fi_inc[pItrLength-1:0];
                    // Address is presented on entry to FETCH to give the LUT its cycle.
                    if (fi_inc < kItrs) begin
                        lut_addr_d = fi_inc[pItrLength-1:0];
                        state_d    = StFetch;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (({1'b0, si_q} == kItrs) && !shift_a && !shift_b) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            fi_q       <= '0;
            si_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            lut_addr_q <= '0;
            sh_q       <= '0;
            mi_q       <= '0;
            mb_q       <= '0;
            sel_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fi_q       <= fi_d;
            si_q       <= si_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            lut_addr_q <= lut_addr_d;
            sh_q       <= sh_d;
            mi_q       <= mi_d;
            mb_q       <= mb_d;
            sel_q      <= sel_d;
        end
    end

    swap_unit_tracker u_trk_a (
        .clk           (clk),
        .reset_n       (reset_n),
        .sw_next_itr_i (sw_next_itr_a),
        .issue_grant_i (issue_a),
        .swap_grant_i  (swap_g_a),
        .shifting_o    (shift_a),
        .next_itr_ack_o(sw_next_itr_ack_a),
        .swap_ack_o    (sw_swap_ack_a)
    );

    swap_unit_tracker u_trk_b (
        .clk           (clk),
        .reset_n       (reset_n),
        .sw_next_itr_i (sw_next_itr_b),
        .issue_grant_i (issue_b),
        .swap_grant_i  (swap_g_b),
        .shifting_o    (shift_b),
        .next_itr_ack_o(sw_next_itr_ack_b),
        .swap_ack_o    (sw_swap_ack_b)
    );

    assign busy            = busy_q;
    assign done            = done_q;
    assign lut_addr        = lut_addr_q;
    assign sw_sh_accu_base = sh_q;
    assign sw_mp_accu_init = mi_q;
    assign sw_mp_accu_base = mb_q;
    assign sel             = sel_q;

endmodule

// File: tb/tb_processing_swap_control.sv
// Directed bench: a four-iteration instance and a single-iteration instance,
// each fed by a registered parameter LUT holding 1000+i / 2000+i / 3000+i.
module tb_processing_swap_control;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic         start, nxt_a, nxt_b, swp_a, swp_b;
    logic         busy, done, ack_a, ack_b, sack_a, sack_b, sel;
    logic [2:0]   lut_addr;
    logic [W-1:0] lut_sh, lut_mi, lut_mb, bus_sh, bus_mi, bus_mb;

    logic         start1, nxt_a1, nxt_b1, swp_a1, swp_b1;
    logic         busy1, done1, ack_a1, ack_b1, sack_a1, sack_b1, sel1;
    logic [0:0]   lut_addr1;
    logic [W-1:0] lut_sh1, lut_mi1, lut_mb1, bus_sh1, bus_mi1, bus_mb1;

    int checks = 0;
    int failures = 0;
    int cnt;
    bit b1_seen;

    always_ff @(posedge clk) begin
        lut_sh  <= 16'h1000 + 16'(lut_addr);
        lut_mi  <= 16'h2000 + 16'(lut_addr);
        lut_mb  <= 16'h3000 + 16'(lut_addr);
        lut_sh1 <= 16'h1000 + 16'(lut_addr1);
        lut_mi1 <= 16'h2000 + 16'(lut_addr1);
        lut_mb1 <= 16'h3000 + 16'(lut_addr1);
    end

    always @(negedge clk) if (ack_b1 || sack_b1) b1_seen <= 1'b1;

    processing_swap_control #(
        .pNoOfItrs(4), .pItrLength(3),
        .pShAccuBaseLength(W), .pMapAccuInitLength(W), .pMapAccuBaseLength(W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .lut_addr(lut_addr), .lut_sh_accu_base(lut_sh), .lut_mp_accu_init(lut_mi),
        .lut_mp_accu_base(lut_mb), .sw_sh_accu_base(bus_sh), .sw_mp_accu_init(bus_mi),
        .sw_mp_accu_base(bus_mb), .sw_next_itr_a(nxt_a), .sw_next_itr_b(nxt_b),
        .sw_swap_a(swp_a), .sw_swap_b(swp_b), .sw_next_itr_ack_a(ack_a),
        .sw_next_itr_ack_b(ack_b), .sw_swap_ack_a(sack_a), .sw_swap_ack_b(sack_b),
        .sel(sel)
    );

    processing_swap_control #(
        .pNoOfItrs(1), .pItrLength(1),
        .pShAccuBaseLength(W), .pMapAccuInitLength(W), .pMapAccuBaseLength(W)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .busy(busy1), .done(done1),
        .lut_addr(lut_addr1), .lut_sh_accu_base(lut_sh1), .lut_mp_accu_init(lut_mi1),
        .lut_mp_accu_base(lut_mb1), .sw_sh_accu_base(bus_sh1), .sw_mp_accu_init(bus_mi1),
        .sw_mp_accu_base(bus_mb1), .sw_next_itr_a(nxt_a1), .sw_next_itr_b(nxt_b1),
        .sw_swap_a(swp_a1), .sw_swap_b(swp_b1), .sw_next_itr_ack_a(ack_a1),
        .sw_next_itr_ack_b(ack_b1), .sw_swap_ack_a(sack_a1), .sw_swap_ack_b(sack_b1),
        .sel(sel1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        {start, nxt_a, nxt_b, swp_a, swp_b} = '0;
        {start1, nxt_a1, nxt_b1, swp_a1, swp_b1} = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_acks", {ack_a, ack_b, sack_a, sack_b}, 0);
        check("rst_sel", sel, 0);
        check("rst_lut_addr", lut_addr, 0);
        check("rst_bus", {bus_sh, bus_mi, bus_mb}, 0);
        reset_n = 1'b1;

        // Requests while idle are ignored.
        nxt_a = 1'b1;
        nxt_b = 1'b1;
        cnt = 0;
        repeat (3) begin tick(); if (ack_a || ack_b) cnt++; end
        check("idle_ignore", cnt, 0);

        // Pass 1: first parameter issue three cycles after start.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_on_start", busy, 1);
        tick();
        tick();
        check("ack_a_not_early", ack_a, 0);
        tick();
        check("ack_a_itr0", ack_a, 1);
        check("bus_itr0", {bus_sh, bus_mi, bus_mb}, {16'h1000, 16'h2000, 16'h3000});
        nxt_a = 1'b0;
        tick();
        check("ack_a_pulse", ack_a, 0);
        tick();
        check("ack_b_not_early", ack_b, 0);
        check("bus_itr1_sh", bus_sh, 16'h1001);
        tick();
        check("ack_b_itr1", ack_b, 1);
        check("bus_itr1", {bus_mi, bus_mb}, {16'h2001, 16'h3001});
        nxt_b = 1'b0;

        // Iteration 2 is due for A; a request from B must stay pending.
        nxt_b = 1'b1;
        cnt = 0;
        repeat (4) begin tick(); if (ack_a || ack_b) cnt++; end
        check("wrong_parity", cnt, 0);
        nxt_b = 1'b0;

        swp_a = 1'b1;
        tick();
        check("swap_a_itr0", sack_a, 1);
        check("sel_itr0", sel, 0);
        swp_a = 1'b0;

        // B filled while A still shifts: held off until A reports shift done.
        swp_b = 1'b1;
        cnt = 0;
        repeat (5) begin tick(); if (sack_b) cnt++; end
        check("swap_b_blocked", cnt, 0);
        nxt_a = 1'b1;
        tick();
        check("swap_b_itr1", sack_b, 1);
        check("sel_itr1", sel, 1);
        check("ack_a_itr2", ack_a, 1);
        check("bus_itr2", bus_sh, 16'h1002);
        nxt_a = 1'b0;
        swp_b = 1'b0;

        tick();
        swp_a = 1'b1;
        cnt = 0;
        repeat (3) begin tick(); if (sack_a) cnt++; end
        check("swap_a_blocked", cnt, 0);
        nxt_b = 1'b1;
        tick();
        check("swap_a_itr2", sack_a, 1);
        check("sel_itr2", sel, 0);
        check("ack_b_itr3", ack_b, 1);
        check("bus_itr3", bus_sh, 16'h1003);
        nxt_b = 1'b0;
        swp_a = 1'b0;

        swp_b = 1'b1;
        cnt = 0;
        repeat (3) begin tick(); if (sack_b) cnt++; end
        check("swap_b3_blocked", cnt, 0);
        nxt_a = 1'b1;
        tick();
        check("swap_b_itr3", sack_b, 1);
        check("sel_itr3", sel, 1);
        check("no_ack_in_drain", ack_a, 0);
        check("no_done_early", done, 0);
        swp_b = 1'b0;
        tick();
        check("busy_while_shift", {busy, done}, 2'b10);
        nxt_b = 1'b1;
        tick();
        check("done_pulse", {busy, done}, 2'b01);
        check("b_pending_unacked", ack_b, 0);
        tick();
        check("done_single", done, 0);

        // Pass 2: a mid-pass start is ignored; then a mid-pass reset.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("p2_ack_a", ack_a, 1);
        check("p2_bus0", bus_sh, 16'h1000);
        nxt_a = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("p2_ack_b_order", ack_b, 1);
        check("p2_bus1", bus_sh, 16'h1001);
        nxt_b = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sel", sel, 0);
        check("mid_rst_lut_addr", lut_addr, 0);
        check("mid_rst_bus", {bus_sh, bus_mi, bus_mb}, 0);
        check("mid_rst_acks", {ack_a, ack_b, sack_a, sack_b, done}, 0);

        nxt_a = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("replay_ack_a", ack_a, 1);
        check("replay_bus0", {bus_sh, bus_mi, bus_mb}, {16'h1000, 16'h2000, 16'h3000});
        nxt_a = 1'b0;

        // Single-iteration instance: only A is used.
        nxt_a1 = 1'b1;
        nxt_b1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        tick();
        check("n1_ack_a", ack_a1, 1);
        check("n1_bus0", bus_sh1, 16'h1000);
        nxt_a1 = 1'b0;
        tick();
        swp_a1 = 1'b1;
        tick();
        check("n1_swap_a", sack_a1, 1);
        check("n1_sel", sel1, 0);
        swp_a1 = 1'b0;
        tick();
        tick();
        check("n1_wait", {busy1, done1}, 2'b10);
        nxt_a1 = 1'b1;
        tick();
        check("n1_done", {busy1, done1}, 2'b01);
        tick();
        check("n1_after", {ack_a1, done1}, 0);
        check("n1_b_never", b1_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
